// File: rtl/ber_pkg.sv
// Shared constants and state encoding for the bit-error measurement sequencer.
package ber_pkg;

  localparam int SUMM_PIPE_DEPTH = 8;
  localparam int ERR_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } ber_state_e;

endpackage

// File: rtl/wrap_detect.sv
// Sticky accumulator-wrap detector: flags any cycle where the running error sum
// drops below its previous value.
module wrap_detect
  import ber_pkg::*;
(
  input  logic             clk,
  input  logic             rs,
  input  logic             clr,
  input  logic             en,
  input  logic [ERR_W-1:0] sum_in,
  output logic             ovf_tmp
);

  logic [ERR_W-1:0] prev_q, prev_d;
  logic             ovf_q, ovf_d;

  // At most 64 errors are added per cycle, so a single decrease always marks a wrap.
  always_comb begin
    prev_d = prev_q;
    ovf_d  = ovf_q;
    if (clr) begin
      prev_d = '0;
      ovf_d  = 1'b0;
    end else if (en) begin
      prev_d = sum_in;
      ovf_d  = ovf_q | (sum_in < prev_q);
    end
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf_tmp = ovf_q;

endmodule

// File: rtl/ber_meas_ctrl.sv
// Sequencer for one bit-error measurement window: clear, capture, flush, latch.
// Define BER_THRESH_ALARM_EN to add the thresh input and latched alarm output.
module ber_meas_ctrl
  import ber_pkg::*;
#(
  parameter int WINDOW_WORDS = 16,
  parameter int FLUSH_CYCLES = SUMM_PIPE_DEPTH,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             start,
  input  logic             abort,
  input  logic [ERR_W-1:0] err_sum_in,
`ifdef BER_THRESH_ALARM_EN
  input  logic [ERR_W-1:0] thresh,
  output logic             alarm,
`endif
  output logic             sum_rs,
  output logic             sum_en,
  output logic             sum_en_count,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] result,
  output logic             ovf,
  output logic [CNT_W-1:0] words_done
);

  // state | meaning
  // IDLE  | waiting for start
  // CLEAR | one cycle, summator and wrap tracker cleared
  // COUNT | WINDOW_WORDS cycles of word capture
  // FLUSH | FLUSH_CYCLES cycles draining the adder pipeline with zero words
  // DONE  | one cycle, final count latched, done pulsed
  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_CLEAR = ST_CLEAR;
  localparam logic [2:0] S_COUNT = ST_COUNT;
  localparam logic [2:0] S_FLUSH = ST_FLUSH;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam int              FL_W     = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FL_W-1:0] FL_LOAD  = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_WORDS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FL_W-1:0]  fl_q, fl_d;
  logic [ERR_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             ovf_tmp;

  always_comb begin
    busy         = (state_q == S_CLEAR) || (state_q == S_COUNT) || (state_q == S_FLUSH);
    done         = (state_q == S_DONE);
    sum_en       = (state_q == S_COUNT);
    sum_en_count = (state_q == S_COUNT) || (state_q == S_FLUSH);
    sum_rs       = (state_q == S_CLEAR) || (busy && abort);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fl_d     = fl_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          fl_d    = FL_LOAD;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (fl_q == '0) state_d = S_DONE;
        else            fl_d    = fl_q - FL_W'(1);
      end
      S_DONE: begin
        result_d = err_sum_in;
        ovf_d    = ovf_tmp;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort discards the window; result and ovf keep the last completed one.
    if (busy && abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fl_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fl_q     <= fl_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  wrap_detect u_wrap (
    .clk     (clk),
    .rs      (rs),
    .clr     (state_q == S_CLEAR),
    .en      (sum_en_count),
    .sum_in  (err_sum_in),
    .ovf_tmp (ovf_tmp)
  );

  assign result     = result_q;
  assign ovf        = ovf_q;
  assign words_done = cnt_q;

`ifdef BER_THRESH_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (state_q == S_CLEAR)     alarm_d = 1'b0;
    else if (state_q == S_DONE) alarm_d = (err_sum_in >= thresh) | ovf_tmp;
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) alarm_q <= 1'b0;
    else    alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Self-checking bench for ber_meas_ctrl: table of measurement windows with a
// result scoreboard, plus hand sequences for abort, reset and a 1-word window.
`timescale 1ns/1ps
module tb_ber_meas_ctrl;

  localparam int W  = 16;
  localparam int F  = 8;
  localparam int TH = 100;

  logic        clk = 1'b0;
  logic        rs, start, abort, start1, abort1;
  logic [7:0]  err_sum_in, err1;
  logic        sum_rs, sum_en, sum_en_count, busy, done, ovf;
  logic [7:0]  result;
  logic [15:0] words_done;
  logic        sum_rs1, sum_en1, sum_en_count1, busy1, done1, ovf1;
  logic [7:0]  result1;
  logic [15:0] words_done1;
`ifdef BER_THRESH_ALARM_EN
  logic [7:0]  thresh, thresh1;
  logic        alarm, alarm1;
`endif

  ber_meas_ctrl #(.WINDOW_WORDS(W), .FLUSH_CYCLES(F), .CNT_W(16)) dut (
    .clk(clk), .rs(rs), .start(start), .abort(abort), .err_sum_in(err_sum_in),
`ifdef BER_THRESH_ALARM_EN
    .thresh(thresh), .alarm(alarm),
`endif
    .sum_rs(sum_rs), .sum_en(sum_en), .sum_en_count(sum_en_count), .busy(busy),
    .done(done), .result(result), .ovf(ovf), .words_done(words_done)
  );

  ber_meas_ctrl #(.WINDOW_WORDS(1), .FLUSH_CYCLES(F), .CNT_W(16)) dut1 (
    .clk(clk), .rs(rs), .start(start1), .abort(abort1), .err_sum_in(err1),
`ifdef BER_THRESH_ALARM_EN
    .thresh(thresh1), .alarm(alarm1),
`endif
    .sum_rs(sum_rs1), .sum_en(sum_en1), .sum_en_count(sum_en_count1), .busy(busy1),
    .done(done1), .result(result1), .ovf(ovf1), .words_done(words_done1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic [7:0] exp_res;
    logic       exp_ovf;
    bit         extra_starts;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic       alarm;
  } exp_t;

  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb_q[$];
  exp_t       e;
  logic [7:0] last_res = 8'd0;
  logic       last_ovf = 1'b0;
  logic       done_d1  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {busy, done, sum_rs, sum_en, sum_en_count} for cycle c after start (start in cycle 0).
  function automatic logic [4:0] ctl_model(input int c, input int ab, input int ww, input int fc);
    logic bz, cnt, fl;
    if (ab >= 1 && ab <= ww + fc + 1 && c > ab) return 5'b0;
    bz  = (c >= 1) && (c <= ww + fc + 1);
    cnt = (c >= 2) && (c <= ww + 1);
    fl  = (c >= ww + 2) && (c <= ww + fc + 1);
    return {bz, c == ww + fc + 2, (c == 1) || (bz && c == ab), cnt, cnt || fl};
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] r, input logic o);
    exp_t x;
    x.res   = r;
    x.ovf   = o;
    x.alarm = (r >= 8'(TH)) | o;
    return x;
  endfunction

  // Scoreboard consumer: one cycle after done, the latched result must match.
  always @(negedge clk) begin
    if (done_d1) begin
      if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("words_done", 32'(words_done), 32'(W));
`ifdef BER_THRESH_ALARM_EN
        chk("alarm", 32'(alarm), 32'(e.alarm));
`endif
        last_res = e.res;
        last_ovf = e.ovf;
      end
    end
    done_d1 = done & ~rs;
  end

  task automatic run_window(input logic [7:0] base, input logic [7:0] step,
                            input logic [7:0] exp_res, input logic exp_ovf,
                            input int abort_at, input int rs_at, input bit extra_starts);
    int last_c;
    bit real_abort;
    real_abort = (abort_at >= 1) && (abort_at <= W + F + 1);
    last_c = real_abort ? abort_at + 1 : (rs_at >= 0 ? rs_at : W + F + 3);
    if (!real_abort && rs_at < 0) sb_q.push_back(mk_exp(exp_res, exp_ovf));
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (extra_starts && (c == 5 || c == W + F + 2));
      abort = (c == abort_at);
      if (c < 2) err_sum_in = 8'd0;
      else if (c <= W + 1) err_sum_in = 8'(int'(base) + int'(step) * (c - 2));
      if (c == rs_at) begin
        rs = 1'b1;
        #1;
        chk("rs_outputs", {busy, done, sum_rs, sum_en, sum_en_count, ovf, result, words_done},
            32'd0);
        @(negedge clk);
        rs = 1'b0;
        last_res = 8'd0;
        last_ovf = 1'b0;
        break;
      end
      @(negedge clk);
      chk("ctl", 32'({busy, done, sum_rs, sum_en, sum_en_count}), 32'(ctl_model(c, abort_at, W, F)));
`ifdef BER_THRESH_ALARM_EN
      if (c == 2) chk("alarm_clr", 32'(alarm), 32'd0);
`endif
    end
    start = 1'b0;
    abort = 1'b0;
    if (real_abort) begin
      chk("abort_result_kept", 32'(result), 32'(last_res));
      chk("abort_ovf_kept", 32'(ovf), 32'(last_ovf));
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'd0,   8'd0,  8'd0,   1'b0, 1'b1};
    vecs[1] = '{8'd0,   8'd10, 8'd150, 1'b0, 1'b0};
    vecs[2] = '{8'd250, 8'd10, 8'd144, 1'b1, 1'b0};
    vecs[3] = '{8'd5,   8'd3,  8'd50,  1'b0, 1'b0};
    vecs[4] = '{8'd200, 8'd20, 8'd244, 1'b1, 1'b0};
    vecs[5] = '{8'd0,   8'd8,  8'd120, 1'b0, 1'b0};
    vecs[6] = '{8'd9,   8'd6,  8'd99,  1'b0, 1'b0};

    rs = 1'b1; start = 1'b0; abort = 1'b0; err_sum_in = 8'd0;
    start1 = 1'b0; abort1 = 1'b0; err1 = 8'd7;
`ifdef BER_THRESH_ALARM_EN
    thresh = 8'(TH); thresh1 = 8'(TH);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, sum_rs, sum_en, sum_en_count, ovf, result, words_done}, 32'd0);
`ifdef BER_THRESH_ALARM_EN
    chk("reset_alarm", 32'(alarm), 32'd0);
`endif
    @(negedge clk);
    rs = 1'b0;

    for (int i = 0; i < 7; i++)
      run_window(vecs[i].base, vecs[i].step, vecs[i].exp_res, vecs[i].exp_ovf, -1, -1,
                 vecs[i].extra_starts);

    // Abort during COUNT after a wrapped window, then a clean window.
    run_window(8'd250, 8'd10, 8'd144, 1'b1, -1, -1, 1'b0);
    run_window(8'd0, 8'd10, 8'd0, 1'b0, 10, -1, 1'b0);
    run_window(8'd0, 8'd10, 8'd150, 1'b0, -1, -1, 1'b0);
    // Abort in CLEAR and in FLUSH.
    run_window(8'd1, 8'd1, 8'd0, 1'b0, 1, -1, 1'b0);
    run_window(8'd1, 8'd1, 8'd0, 1'b0, 20, -1, 1'b0);
    // Abort with start in IDLE (start wins), abort in DONE (ignored).
    run_window(8'd3, 8'd2, 8'd33, 1'b0, 0, -1, 1'b0);
    run_window(8'd3, 8'd1, 8'd18, 1'b0, W + F + 2, -1, 1'b0);
    // Reset mid-window.
    run_window(8'd0, 8'd5, 8'd0, 1'b0, -1, 12, 1'b0);
    run_window(8'd2, 8'd4, 8'd62, 1'b0, -1, -1, 1'b0);

    // One-word window on the second instance.
    for (int c = 0; c <= F + 4; c++) begin
      @(posedge clk); #1;
      start1 = (c == 0);
      @(negedge clk);
      chk("w1_ctl", 32'({busy1, done1, sum_rs1, sum_en1, sum_en_count1}), 32'(ctl_model(c, -1, 1, F)));
    end
    chk("w1_words_done", 32'(words_done1), 32'd1);
    chk("w1_result", 32'(result1), 32'd7);
    chk("w1_ovf", 32'(ovf1), 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
